os_result_drain: RTL and testbench

OS_RESULT_DRAIN -- requirements
Module: os_result_drain

---
 rtl/os_pkg.sv | 14 +
 rtl/os_drain_buf.sv | 42 ++++
 rtl/os_result_drain.sv | 127 ++++++++++++
 tb/tb_os_result_drain.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/os_pkg.sv
// Shared definitions for the output-stationary result drain: default result
// width and the drain FSM state encoding.
package os_pkg;

    localparam int ACC_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CAPT,
        STREAM
    } drain_state_e;

endpackage

// File: rtl/os_drain_buf.sv
// Local copy of a column's PE shadow results, captured in one cycle and read
// back one word at a time through an index-driven mux.
module os_drain_buf
    import os_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int NUM_ROWS  = 4,
    parameter int IDX_W     = $clog2(NUM_ROWS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cap_en,
    input  logic [NUM_ROWS*ACC_WIDTH-1:0] shadow_in,
    input  logic [IDX_W-1:0]              idx,
    output logic [ACC_WIDTH-1:0]          word
);

    logic [ACC_WIDTH-1:0] mem_q [NUM_ROWS];
    logic [ACC_WIDTH-1:0] mem_d [NUM_ROWS];

    always_comb begin
        mem_d = mem_q;
        if (cap_en) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                mem_d[r] = shadow_in[r*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign word = mem_q[idx];

endmodule

// File: rtl/os_result_drain.sv
// Drains one systolic column: strobes the PEs to shadow their results, captures
// them, then streams them out row by row. Optional OS_RESULT_DRAIN_SAT_FLAG_EN adds out_sat.
module os_result_drain
    import os_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int NUM_ROWS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_ROWS*ACC_WIDTH-1:0] shadow_in,
    output logic                          load_en,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_ROWS)-1:0]   out_idx,
    output logic                          out_last,
    output logic                          drain_done
`ifdef OS_RESULT_DRAIN_SAT_FLAG_EN
    ,
    output logic                          out_sat
`endif
);

    localparam int                IDX_W    = $clog2(NUM_ROWS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ROWS - 1);

    drain_state_e         state_q, state_d;
    logic                 load_en_q, load_en_d;
    logic                 busy_q, busy_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 drain_done_q, drain_done_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 xfer;
    logic [ACC_WIDTH-1:0] buf_word;

    assign xfer = out_valid_q && out_ready;

    // Outputs are derived from the next state so they line up with the state flop.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        drain_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = CAPT;
            end
            CAPT: begin
                state_d = STREAM;
                idx_d   = '0;
            end
            STREAM: begin
                if (xfer) begin
                    if (out_last_q) begin
                        state_d      = IDLE;
                        idx_d        = '0;
                        drain_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        load_en_d   = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == STREAM);
        out_last_d  = out_valid_d && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            load_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            drain_done_q <= 1'b0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            load_en_q    <= load_en_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            drain_done_q <= drain_done_d;
            idx_q        <= idx_d;
        end
    end

    os_drain_buf #(
        .ACC_WIDTH (ACC_WIDTH),
        .NUM_ROWS  (NUM_ROWS),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_en    (state_q == CAPT),
        .shadow_in (shadow_in),
        .idx       (idx_q),
        .word      (buf_word)
    );

    assign load_en    = load_en_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign drain_done = drain_done_q;
    assign out_idx    = idx_q;
    // Buffer contents are masked so the data bus reads zero whenever no word is offered.
    assign out_data   = out_valid_q ? buf_word : '0;

`ifdef OS_RESULT_DRAIN_SAT_FLAG_EN
    assign out_sat = out_valid_q && (&out_data);
`endif

endmodule

// File: tb/tb_os_result_drain.sv
// Randomized self-checking bench for os_result_drain; the expected stream is
// derived from the shadow value at capture time and the ready pattern applied.
module tb_os_result_drain;

    localparam int AW = 24;
    localparam int NR = 4;
    localparam int HL = 48;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [NR*AW-1:0] shadow_in;
    logic             load_en;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_data;
    logic [1:0]       out_idx;
    logic             out_last;
    logic             drain_done;
`ifdef OS_RESULT_DRAIN_SAT_FLAG_EN
    logic             out_sat;
`endif

    os_result_drain #(.ACC_WIDTH(AW), .NUM_ROWS(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .shadow_in  (shadow_in),
        .load_en    (load_en),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .drain_done (drain_done)
`ifdef OS_RESULT_DRAIN_SAT_FLAG_EN
        ,
        .out_sat    (out_sat)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    localparam logic [NR*AW-1:0] BASE = {24'h4, 24'h3, 24'h2, 24'h1};

    int            c0, last_rel, timed_out, n_exp;
    int            hold_err, idle_err, busy_err, valid_err, load_err;
    logic [AW-1:0] got_data[$];
    int            got_idx[$];
    int            got_last[$];
    int            got_cyc[$];
    int            got_sat[$];
    logic          ready_hist[HL];
    logic          busy_hist[HL];
    logic          valid_hist[HL];
    logic          load_hist[HL];
    int            exp_cyc[NR];
    logic [AW-1:0] exp_word[NR];
    logic [NR*AW-1:0] cap;

    function automatic logic rdy(input int mode, input int r);
        if (mode == 0) return 1'b1;
        if (mode == 1) return !(r >= 3 && r <= 5);
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one start-to-done burst, recording what the DUT did, then builds the
    // expected stream: words captured from shadow_in at c2, the k-th word moving
    // on the k-th ready cycle from c3 on, drain_done the cycle after the last.
    task automatic run_burst(input logic [NR*AW-1:0] shadow, input int mode,
                             input int restart_at, input int chg_at,
                             input logic [NR*AW-1:0] chg_val, input int stop_after);
        logic          prev_stall;
        logic [AW-1:0] prev_data;
        int            prev_idx;
        logic          prev_last;
        int            end_r;
        got_data.delete(); got_idx.delete(); got_last.delete();
        got_cyc.delete();  got_sat.delete();
        timed_out = 1; hold_err = 0; idle_err = 0; last_rel = -1;
        prev_stall = 1'b0; prev_data = '0; prev_idx = 0; prev_last = 1'b0;
        @(posedge clk); #1;
        shadow_in = shadow;
        c0        = cyc;
        start     = 1'b1;
        for (int r = 0; r < HL; r++) begin
            if (r > 0) begin
                @(posedge clk); #1;
                start = (r == restart_at);
                if (r == chg_at) shadow_in = chg_val;
            end
            out_ready     = rdy(mode, r);
            ready_hist[r] = out_ready;
            @(negedge clk);
            busy_hist[r]  = busy;
            valid_hist[r] = out_valid;
            load_hist[r]  = load_en;
            if (r == 2) cap = shadow_in;
            if (prev_stall && (out_data !== prev_data || int'(out_idx) !== prev_idx ||
                               out_last !== prev_last)) hold_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = int'(out_idx);
            prev_last  = out_last;
            if (!out_valid && (out_data !== '0 || out_last !== 1'b0)) idle_err++;
            if (out_valid === 1'b1 && out_ready) begin
                got_data.push_back(out_data);
                got_idx.push_back(int'(out_idx));
                got_last.push_back(int'(out_last));
                got_cyc.push_back(r);
`ifdef OS_RESULT_DRAIN_SAT_FLAG_EN
                got_sat.push_back(int'(out_sat));
`endif
            end
            if (drain_done === 1'b1 ||
                (stop_after > 0 && got_data.size() == stop_after)) begin
                last_rel  = r;
                timed_out = 0;
                break;
            end
        end
        start = 1'b0;
        end_r = (last_rel >= 0) ? last_rel : HL - 1;
        n_exp = 0;
        for (int r = 3; r <= end_r; r++) begin
            if (ready_hist[r] && n_exp < NR) begin
                exp_cyc[n_exp] = r;
                n_exp++;
            end
        end
        for (int k = 0; k < NR; k++) exp_word[k] = cap[k*AW +: AW];
        if (n_exp == NR) end_r = exp_cyc[NR-1];
        busy_err = 0; valid_err = 0; load_err = 0;
        for (int r = 0; r <= ((last_rel >= 0) ? last_rel : HL - 1); r++) begin
            if (busy_hist[r]  !== (r >= 1 && r <= end_r)) busy_err++;
            if (valid_hist[r] !== (r >= 3 && r <= end_r)) valid_err++;
            if (load_hist[r]  !== (r == 1))               load_err++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; shadow_in = '0;
        #12;
        total++;
        if ({load_en, busy, out_valid, out_last, drain_done, out_idx, out_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {load_en, busy, out_valid, out_last, drain_done, out_idx, out_data});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({load_en, busy, out_valid, drain_done} !== 4'b0) begin
            bad++;
            $display("FAIL reset_release_idle got=%b want=0000",
                     {load_en, busy, out_valid, drain_done});
        end
    endtask

    task automatic test_basic();
        run_burst(BASE, 0, -1, -1, '0, 0);
        total++;
        if (timed_out !== 0 || got_data.size() !== NR) begin
            bad++;
            $display("FAIL basic_count got=%0d want=%0d timeout=%0d", got_data.size(), NR, timed_out);
        end
        for (int k = 0; k < got_data.size() && k < NR; k++) begin
            total++;
            if (got_data[k] !== exp_word[k] || got_idx[k] !== k || got_last[k] !== int'(k == NR-1) ||
                got_cyc[k] !== exp_cyc[k]) begin
                bad++;
                $display("FAIL basic_word[%0d] got=%h/idx%0d/last%0d/c%0d want=%h/idx%0d/last%0d/c%0d",
                         k, got_data[k], got_idx[k], got_last[k], got_cyc[k],
                         exp_word[k], k, int'(k == NR-1), exp_cyc[k]);
            end
        end
        total++;
        if (last_rel !== 7) begin
            bad++;
            $display("FAIL basic_done_cycle got=%0d want=7", last_rel);
        end
        total++;
        if (busy_err + valid_err + load_err + hold_err + idle_err !== 0) begin
            bad++;
            $display("FAIL basic_ctrl got=busy%0d/valid%0d/load%0d/hold%0d/idle%0d want=0",
                     busy_err, valid_err, load_err, hold_err, idle_err);
        end
    endtask

    task automatic test_backpressure();
        run_burst(BASE, 1, -1, -1, '0, 0);
        total++;
        if (timed_out !== 0 || got_data.size() !== NR) begin
            bad++;
            $display("FAIL bp_count got=%0d want=%0d", got_data.size(), NR);
        end
        for (int k = 0; k < got_data.size() && k < NR; k++) begin
            total++;
            if (got_data[k] !== exp_word[k] || got_idx[k] !== k || got_cyc[k] !== 6 + k) begin
                bad++;
                $display("FAIL bp_word[%0d] got=%h/idx%0d/c%0d want=%h/idx%0d/c%0d",
                         k, got_data[k], got_idx[k], got_cyc[k], exp_word[k], k, 6 + k);
            end
        end
        total++;
        if (hold_err + valid_err + busy_err !== 0 || last_rel !== 10) begin
            bad++;
            $display("FAIL bp_hold got=hold%0d/valid%0d/busy%0d/done_c%0d want=0/0/0/10",
                     hold_err, valid_err, busy_err, last_rel);
        end
    endtask

    task automatic test_restart_ignored();
        int extra;
        run_burst(BASE, 0, 4, -1, '0, 0);
        total++;
        if (timed_out !== 0 || got_data.size() !== NR || busy_err + valid_err !== 0) begin
            bad++;
            $display("FAIL restart_burst got=n%0d/busy%0d/valid%0d want=n%0d/0/0",
                     got_data.size(), busy_err, valid_err, NR);
        end
        extra = 0;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            if (busy !== 1'b0 || load_en !== 1'b0 || out_valid !== 1'b0) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL restart_queued got=%0d busy cycles want=0", extra);
        end
    endtask

    task automatic test_shadow_change();
        run_burst(BASE, 0, -1, 4, {NR{24'hABCDEF}}, 0);
        total++;
        if (got_data.size() !== NR) begin
            bad++;
            $display("FAIL shadow_count got=%0d want=%0d", got_data.size(), NR);
        end
        for (int k = 0; k < got_data.size() && k < NR; k++) begin
            total++;
            if (got_data[k] !== AW'(k + 1)) begin
                bad++;
                $display("FAIL shadow_word[%0d] got=%h want=%h", k, got_data[k], AW'(k + 1));
            end
        end
    endtask

    task automatic test_midstream_reset();
        run_burst(BASE, 0, -1, -1, '0, 2);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({load_en, busy, out_valid, out_last, drain_done, out_idx, out_data} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=0",
                     {load_en, busy, out_valid, out_last, drain_done, out_idx, out_data});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        run_burst(BASE, 0, -1, -1, '0, 0);
        total++;
        if (timed_out !== 0 || got_data.size() !== NR) begin
            bad++;
            $display("FAIL midreset_count got=%0d want=%0d", got_data.size(), NR);
        end
        for (int k = 0; k < got_data.size() && k < NR; k++) begin
            total++;
            if (got_data[k] !== exp_word[k] || got_idx[k] !== k || got_cyc[k] !== exp_cyc[k]) begin
                bad++;
                $display("FAIL midreset_word[%0d] got=%h/idx%0d/c%0d want=%h/idx%0d/c%0d",
                         k, got_data[k], got_idx[k], got_cyc[k], exp_word[k], k, exp_cyc[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [NR*AW-1:0] s;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < NR; k++) s[k*AW +: AW] = AW'($urandom);
            if (b % 3 == 0) s[($urandom_range(0, NR-1))*AW +: AW] = '1;
            run_burst(s, 2, ($urandom_range(0, 1) == 1) ? 5 : -1, 4, ~s, 0);
            total++;
            if (timed_out !== 0 || got_data.size() !== NR || n_exp !== NR) begin
                bad++;
                $display("FAIL rand%0d_count got=%0d want=%0d", b, got_data.size(), NR);
            end
            for (int k = 0; k < got_data.size() && k < NR; k++) begin
                total++;
                if (got_data[k] !== exp_word[k] || got_idx[k] !== k ||
                    got_last[k] !== int'(k == NR-1) || got_cyc[k] !== exp_cyc[k]) begin
                    bad++;
                    $display("FAIL rand%0d_word[%0d] got=%h/idx%0d/c%0d want=%h/idx%0d/c%0d",
                             b, k, got_data[k], got_idx[k], got_cyc[k], exp_word[k], k, exp_cyc[k]);
                end
            end
            total++;
            if (last_rel !== exp_cyc[NR-1] + 1 ||
                busy_err + valid_err + load_err + hold_err + idle_err !== 0) begin
                bad++;
                $display("FAIL rand%0d_ctrl got=done_c%0d/b%0d/v%0d/l%0d/h%0d/i%0d want=done_c%0d/0/0/0/0/0",
                         b, last_rel, busy_err, valid_err, load_err, hold_err, idle_err,
                         exp_cyc[NR-1] + 1);
            end
        end
    endtask

`ifdef OS_RESULT_DRAIN_SAT_FLAG_EN
    task automatic test_sat();
        run_burst({24'h4, 24'hFFFFFF, 24'h2, 24'h1}, 1, -1, -1, '0, 0);
        total++;
        if (got_sat.size() !== NR) begin
            bad++;
            $display("FAIL sat_count got=%0d want=%0d", got_sat.size(), NR);
        end
        for (int k = 0; k < got_sat.size() && k < NR; k++) begin
            total++;
            if (got_sat[k] !== int'(k == 2)) begin
                bad++;
                $display("FAIL sat_flag[%0d] got=%0d want=%0d", k, got_sat[k], int'(k == 2));
            end
        end
        @(negedge clk);
        total++;
        if (out_sat !== 1'b0) begin
            bad++;
            $display("FAIL sat_idle got=%b want=0", out_sat);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_restart_ignored();
        test_shadow_change();
        test_midstream_reset();
        test_random();
`ifdef OS_RESULT_DRAIN_SAT_FLAG_EN
        test_sat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
